axis_pixel_packer: RTL and testbench



---
 rtl/axis_pixel_packer_pkg.sv | 15 +
 rtl/axis_pixel_packer.sv | 138 +++++++++++++
 tb/tb_axis_pixel_packer.sv | 386 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_pixel_packer_pkg.sv
// Shared definitions for the write-side pixel packing path: pixel width,
// bit offsets of the two pixel slots inside a packed PSRAM word, and the
// packer FSM encoding.
package axis_pixel_packer_pkg;

    localparam int PIX_W    = 24;
    localparam int PIX0_LSB = 0;
    localparam int PIX1_LSB = 32;

    typedef enum logic {
        EMPTY = 1'b0,
        HALF  = 1'b1
    } state_t;

endpackage

// File: rtl/axis_pixel_packer.sv
// Packs a 24-bit RGB pixel AXI-Stream into 64-bit words of two pixels each
// for the PSRAM write burst engine. A line that ends on an odd pixel, or a
// start of frame that arrives while half a word is held, closes the word
// with PAD_PIXEL in the upper slot. The output side is a one-entry register
// slice, so full throughput (one pixel per cycle) is kept under ready=1.
module axis_pixel_packer
    import axis_pixel_packer_pkg::*;
#(
    parameter int          DQ_WIDTH  = 16,
    parameter logic [23:0] PAD_PIXEL = 24'h000000,
    parameter int          CNT_WIDTH = 16
) (
    input  logic                  pixclk,
    input  logic                  rst_n,
    input  logic                  in_axis_tvalid,
    output logic                  in_axis_tready,
    input  logic                  in_axis_tuser,
    input  logic                  in_axis_tlast,
    input  logic [PIX_W-1:0]      in_axis_tdata,
    output logic                  out_axis_tvalid,
    input  logic                  out_axis_tready,
    output logic                  out_axis_tuser,
    output logic                  out_axis_tlast,
    output logic [4*DQ_WIDTH-1:0] out_axis_tdata,
    output logic [CNT_WIDTH-1:0]  pad_count_o,
    output logic                  misalign_o
);

    localparam int WORD_W = 4 * DQ_WIDTH;

    // Place two pixels into their slots; unused byte lanes stay zero.
    function automatic logic [WORD_W-1:0] pack_word(input logic [PIX_W-1:0] p0,
                                                    input logic [PIX_W-1:0] p1);
        logic [WORD_W-1:0] w;
        w = '0;
        w[PIX0_LSB +: PIX_W] = p0;
        w[PIX1_LSB +: PIX_W] = p1;
        return w;
    endfunction

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
        return (&c) ? c : c + CNT_WIDTH'(1);
    endfunction

    state_t           state;
    logic             pend_last;
    logic [PIX_W-1:0] hold_pix_p0;
    logic             hold_user_p0;

    logic out_free;
    logic xfer;
    logic pend_emit;
    logic hold_load;

    // The slice can take a word when empty or being drained this cycle.
    // A held end-of-line pixel after a misaligned frame start blocks input
    // until its padded word has been pushed out.
    assign out_free       = ~out_axis_tvalid | out_axis_tready;
    assign in_axis_tready = out_free & ~pend_last;
    assign xfer           = in_axis_tvalid & in_axis_tready;
    assign pend_emit      = pend_last & out_free;
    assign hold_load      = xfer & ((state == EMPTY) ? ~in_axis_tlast : in_axis_tuser);

    // ---- stage p0: pixel hold register (data only, qualified by state) ----
    // Capture the pixel that will become pixel0 of the next word.
    always_ff @(posedge pixclk) begin
        if (hold_load) begin
            hold_pix_p0 <= in_axis_tdata;
        end
    end

    // ---- stage p1: packer FSM, output register slice and status ----
    // Pairs pixels, emits padded words and keeps the pad/misalign status.
    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= EMPTY;
            pend_last       <= 1'b0;
            hold_user_p0    <= 1'b0;
            out_axis_tvalid <= 1'b0;
            out_axis_tuser  <= 1'b0;
            out_axis_tlast  <= 1'b0;
            out_axis_tdata  <= '0;
            pad_count_o     <= '0;
            misalign_o      <= 1'b0;
        end else begin
            misalign_o <= 1'b0;
            if (out_axis_tready) begin
                out_axis_tvalid <= 1'b0;
            end

            if (pend_emit) begin
                // Held pixel was itself an end of line: close it with padding.
                out_axis_tvalid <= 1'b1;
                out_axis_tdata  <= pack_word(hold_pix_p0, PAD_PIXEL);
                out_axis_tuser  <= hold_user_p0;
                out_axis_tlast  <= 1'b1;
                pad_count_o     <= sat_inc(pad_count_o);
                pend_last       <= 1'b0;
                state           <= EMPTY;
            end else if (xfer) begin
                if (state == EMPTY) begin
                    if (in_axis_tlast) begin
                        // Single-pixel remainder of a line.
                        out_axis_tvalid <= 1'b1;
                        out_axis_tdata  <= pack_word(in_axis_tdata, PAD_PIXEL);
                        out_axis_tuser  <= in_axis_tuser;
                        out_axis_tlast  <= 1'b1;
                        pad_count_o     <= sat_inc(pad_count_o);
                    end else begin
                        hold_user_p0 <= in_axis_tuser;
                        state        <= HALF;
                    end
                end else begin
                    if (in_axis_tuser) begin
                        // New frame starts mid-word: flush the orphan pixel,
                        // the new pixel becomes pixel0 of the next word.
                        out_axis_tvalid <= 1'b1;
                        out_axis_tdata  <= pack_word(hold_pix_p0, PAD_PIXEL);
                        out_axis_tuser  <= hold_user_p0;
                        out_axis_tlast  <= 1'b1;
                        pad_count_o     <= sat_inc(pad_count_o);
                        misalign_o      <= 1'b1;
                        hold_user_p0    <= 1'b1;
                        pend_last       <= in_axis_tlast;
                    end else begin
                        out_axis_tvalid <= 1'b1;
                        out_axis_tdata  <= pack_word(hold_pix_p0, in_axis_tdata);
                        out_axis_tuser  <= hold_user_p0;
                        out_axis_tlast  <= in_axis_tlast;
                        state           <= EMPTY;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_pixel_packer.sv
// Self-checking bench for axis_pixel_packer: directed scenarios plus
// randomized streams scored against a queue-based pairing model.
module tb_axis_pixel_packer;

    localparam logic [23:0] TB_PAD = 24'hC0FFEE;

    typedef struct packed {
        logic [23:0] d;
        logic        u;
        logic        l;
    } pix_t;

    typedef struct packed {
        logic [63:0] d;
        logic        u;
        logic        l;
    } word_t;

    logic        pixclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_axis_tvalid = 1'b0;
    logic        in_axis_tready;
    logic        in_axis_tuser = 1'b0;
    logic        in_axis_tlast = 1'b0;
    logic [23:0] in_axis_tdata = '0;
    logic        out_axis_tvalid;
    logic        out_axis_tready = 1'b1;
    logic        out_axis_tuser;
    logic        out_axis_tlast;
    logic [63:0] out_axis_tdata;
    logic [15:0] pad_count_o;
    logic        misalign_o;

    axis_pixel_packer #(
        .DQ_WIDTH (16),
        .PAD_PIXEL(TB_PAD),
        .CNT_WIDTH(16)
    ) dut (
        .pixclk         (pixclk),
        .rst_n          (rst_n),
        .in_axis_tvalid (in_axis_tvalid),
        .in_axis_tready (in_axis_tready),
        .in_axis_tuser  (in_axis_tuser),
        .in_axis_tlast  (in_axis_tlast),
        .in_axis_tdata  (in_axis_tdata),
        .out_axis_tvalid(out_axis_tvalid),
        .out_axis_tready(out_axis_tready),
        .out_axis_tuser (out_axis_tuser),
        .out_axis_tlast (out_axis_tlast),
        .out_axis_tdata (out_axis_tdata),
        .pad_count_o    (pad_count_o),
        .misalign_o     (misalign_o)
    );

    always #5 pixclk = ~pixclk;

    pix_t  stim_q[$];
    word_t exp_q[$];
    word_t got_q[$];
    int    got_base = 0;
    int    n_vec = 0;
    int    n_err = 0;
    bit    rec_en = 1'b1;
    int    mis_cnt = 0;

    // reference model state
    bit          m_half = 1'b0;
    logic [23:0] m_pix = '0;
    logic        m_user = 1'b0;
    logic [15:0] exp_pad = '0;
    int          mis_exp = 0;

    // observations from run_stream
    int rdy_drop, stall_unstable, stall_rdy_hi;
    bit stall_seen;

    // Output monitor: record every completed output handshake and misalign pulse.
    always @(negedge pixclk) begin : mon
        word_t w;
        if (rec_en && out_axis_tvalid && out_axis_tready) begin
            w.d = out_axis_tdata;
            w.u = out_axis_tuser;
            w.l = out_axis_tlast;
            got_q.push_back(w);
        end
        if (misalign_o) mis_cnt++;
    end

    function automatic word_t mk_word(input logic [23:0] p0, input logic [23:0] p1,
                                      input logic u, input logic l);
        word_t w;
        w.d = {8'h00, p1, 8'h00, p0};
        w.u = u;
        w.l = l;
        return w;
    endfunction

    function automatic logic [15:0] sat16(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    task automatic model_reset();
        m_half  = 1'b0;
        exp_pad = '0;
    endtask

    task automatic new_stream();
        stim_q.delete();
        exp_q.delete();
        got_base = got_q.size();
    endtask

    task automatic push_pix(input logic [23:0] d, input logic u, input logic l);
        pix_t p;
        p.d = d; p.u = u; p.l = l;
        stim_q.push_back(p);
    endtask

    task automatic gen_random(input int n);
        for (int i = 0; i < n; i++) begin
            push_pix(24'($urandom), (i == 0) || ($urandom_range(99) < 4),
                     $urandom_range(99) < 15);
        end
    endtask

    // Pair pixels into words following the packing rules, pad where needed.
    task automatic build_expected();
        for (int i = 0; i < stim_q.size(); i++) begin
            pix_t p;
            p = stim_q[i];
            if (!m_half) begin
                if (p.l) begin
                    exp_q.push_back(mk_word(p.d, TB_PAD, p.u, 1'b1));
                    exp_pad = sat16(exp_pad);
                end else begin
                    m_half = 1'b1; m_pix = p.d; m_user = p.u;
                end
            end else if (p.u) begin
                exp_q.push_back(mk_word(m_pix, TB_PAD, m_user, 1'b1));
                exp_pad = sat16(exp_pad);
                mis_exp++;
                if (p.l) begin
                    exp_q.push_back(mk_word(p.d, TB_PAD, 1'b1, 1'b1));
                    exp_pad = sat16(exp_pad);
                    m_half = 1'b0;
                end else begin
                    m_pix = p.d; m_user = p.u;
                end
            end else begin
                exp_q.push_back(mk_word(m_pix, p.d, m_user, p.l));
                m_half = 1'b0;
            end
        end
    endtask

    task automatic run_stream(input int vld_pct, input int rdy_pct,
                              input int stall_at, input int stall_len);
        int idx = 0;
        int cyc = 0;
        int limit;
        word_t held;
        limit = 30 * stim_q.size() + 100;
        rdy_drop = 0; stall_unstable = 0; stall_rdy_hi = 0; stall_seen = 1'b0;
        held = '0;
        while ((idx < stim_q.size() || (got_q.size() - got_base) < exp_q.size()) && cyc < limit) begin
            @(posedge pixclk); #1;
            if (idx < stim_q.size() && $urandom_range(99) < vld_pct) begin
                in_axis_tvalid = 1'b1;
                in_axis_tdata  = stim_q[idx].d;
                in_axis_tuser  = stim_q[idx].u;
                in_axis_tlast  = stim_q[idx].l;
            end else begin
                in_axis_tvalid = 1'b0;
                in_axis_tdata  = 24'($urandom);
                in_axis_tuser  = 1'b0;
                in_axis_tlast  = 1'b0;
            end
            if (cyc >= stall_at && cyc < stall_at + stall_len) out_axis_tready = 1'b0;
            else out_axis_tready = ($urandom_range(99) < rdy_pct);
            @(negedge pixclk);
            if (in_axis_tvalid && !in_axis_tready) rdy_drop++;
            if (cyc >= stall_at && cyc < stall_at + stall_len && out_axis_tvalid) begin
                if (!stall_seen) begin
                    held = mk_word(out_axis_tdata[23:0], out_axis_tdata[55:32], out_axis_tuser, out_axis_tlast);
                    held.d = out_axis_tdata;
                    stall_seen = 1'b1;
                end else if ({out_axis_tdata, out_axis_tuser, out_axis_tlast} !== held) begin
                    stall_unstable++;
                end
                if (in_axis_tready) stall_rdy_hi++;
            end
            if (in_axis_tvalid && in_axis_tready) idx++;
            cyc++;
        end
        @(posedge pixclk); #1;
        in_axis_tvalid  = 1'b0;
        out_axis_tready = 1'b1;
        n_vec++;
        if (cyc >= limit) begin
            n_err++;
            $display("FAIL stream_timeout: %0d of %0d pixels, %0d of %0d words after %0d cycles",
                     idx, stim_q.size(), got_q.size() - got_base, exp_q.size(), cyc);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge pixclk);
        n_vec++; if (out_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL rst_tvalid: got %b want 0", out_axis_tvalid); end
        n_vec++; if (out_axis_tuser !== 1'b0) begin n_err++; $display("FAIL rst_tuser: got %b want 0", out_axis_tuser); end
        n_vec++; if (out_axis_tlast !== 1'b0) begin n_err++; $display("FAIL rst_tlast: got %b want 0", out_axis_tlast); end
        n_vec++; if (out_axis_tdata !== 64'h0) begin n_err++; $display("FAIL rst_tdata: got %h want 0", out_axis_tdata); end
        n_vec++; if (pad_count_o !== 16'h0) begin n_err++; $display("FAIL rst_pad: got %h want 0", pad_count_o); end
        n_vec++; if (misalign_o !== 1'b0) begin n_err++; $display("FAIL rst_misalign: got %b want 0", misalign_o); end
        n_vec++; if (in_axis_tready !== 1'b1) begin n_err++; $display("FAIL rst_tready: got %b want 1", in_axis_tready); end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_line4();
        logic [23:0] a, b, c, d;
        a = 24'($urandom); b = 24'($urandom); c = 24'($urandom); d = 24'($urandom);
        new_stream();
        push_pix(a, 1'b1, 1'b0); push_pix(b, 1'b0, 1'b0);
        push_pix(c, 1'b0, 1'b0); push_pix(d, 1'b0, 1'b1);
        build_expected();
        run_stream(100, 100, 0, 0);
        n_vec++; if (got_q.size() - got_base !== 2) begin n_err++; $display("FAIL line4_count: got %0d want 2", got_q.size() - got_base); end
        if (got_q.size() - got_base >= 2) begin
            n_vec++; if (got_q[got_base] !== mk_word(a, b, 1'b1, 1'b0)) begin n_err++; $display("FAIL line4_w0: got %h/%b/%b want %h/1/0", got_q[got_base].d, got_q[got_base].u, got_q[got_base].l, {8'h00, b, 8'h00, a}); end
            n_vec++; if (got_q[got_base+1] !== mk_word(c, d, 1'b0, 1'b1)) begin n_err++; $display("FAIL line4_w1: got %h/%b/%b want %h/0/1", got_q[got_base+1].d, got_q[got_base+1].u, got_q[got_base+1].l, {8'h00, d, 8'h00, c}); end
        end
        n_vec++; if (rdy_drop !== 0) begin n_err++; $display("FAIL line4_tready: got %0d stalled cycles want 0", rdy_drop); end
    endtask

    task automatic test_pad3();
        new_stream();
        push_pix(24'h111111, 1'b1, 1'b0); push_pix(24'h222222, 1'b0, 1'b0); push_pix(24'h333333, 1'b0, 1'b1);
        build_expected();
        run_stream(100, 100, 0, 0);
        n_vec++; if (got_q.size() - got_base !== 2) begin n_err++; $display("FAIL pad3_count: got %0d want 2", got_q.size() - got_base); end
        if (got_q.size() - got_base >= 2) begin
            n_vec++; if (got_q[got_base] !== mk_word(24'h111111, 24'h222222, 1'b1, 1'b0)) begin n_err++; $display("FAIL pad3_w0: got %h/%b/%b", got_q[got_base].d, got_q[got_base].u, got_q[got_base].l); end
            n_vec++; if (got_q[got_base+1] !== mk_word(24'h333333, TB_PAD, 1'b0, 1'b1)) begin n_err++; $display("FAIL pad3_w1: got %h/%b/%b want %h/0/1", got_q[got_base+1].d, got_q[got_base+1].u, got_q[got_base+1].l, {8'h00, TB_PAD, 8'h00, 24'h333333}); end
        end
        n_vec++; if (pad_count_o !== 16'd1) begin n_err++; $display("FAIL pad3_padcnt: got %0d want 1", pad_count_o); end
    endtask

    task automatic test_misalign();
        logic [23:0] p, q, r;
        int mb;
        p = 24'($urandom); q = 24'($urandom); r = 24'($urandom);
        mb = mis_cnt;
        new_stream();
        push_pix(p, 1'b0, 1'b0); push_pix(q, 1'b1, 1'b0); push_pix(r, 1'b0, 1'b1);
        build_expected();
        run_stream(100, 100, 0, 0);
        n_vec++; if (got_q.size() - got_base !== 2) begin n_err++; $display("FAIL mis_count: got %0d want 2", got_q.size() - got_base); end
        if (got_q.size() - got_base >= 2) begin
            n_vec++; if (got_q[got_base] !== mk_word(p, TB_PAD, 1'b0, 1'b1)) begin n_err++; $display("FAIL mis_w0: got %h/%b/%b", got_q[got_base].d, got_q[got_base].u, got_q[got_base].l); end
            n_vec++; if (got_q[got_base+1] !== mk_word(q, r, 1'b1, 1'b1)) begin n_err++; $display("FAIL mis_w1: got %h/%b/%b", got_q[got_base+1].d, got_q[got_base+1].u, got_q[got_base+1].l); end
        end
        n_vec++; if (mis_cnt - mb !== 1) begin n_err++; $display("FAIL mis_pulse: got %0d pulses want 1", mis_cnt - mb); end
        n_vec++; if (pad_count_o !== 16'd2) begin n_err++; $display("FAIL mis_padcnt: got %0d want 2", pad_count_o); end
        // misaligned start-of-frame pixel that is also an end of line
        mb = mis_cnt;
        new_stream();
        push_pix(p, 1'b0, 1'b0); push_pix(q, 1'b1, 1'b1);
        build_expected();
        run_stream(100, 100, 0, 0);
        n_vec++; if (got_q.size() - got_base !== 2) begin n_err++; $display("FAIL misl_count: got %0d want 2", got_q.size() - got_base); end
        if (got_q.size() - got_base >= 2) begin
            n_vec++; if (got_q[got_base] !== mk_word(p, TB_PAD, 1'b0, 1'b1)) begin n_err++; $display("FAIL misl_w0: got %h/%b/%b", got_q[got_base].d, got_q[got_base].u, got_q[got_base].l); end
            n_vec++; if (got_q[got_base+1] !== mk_word(q, TB_PAD, 1'b1, 1'b1)) begin n_err++; $display("FAIL misl_w1: got %h/%b/%b", got_q[got_base+1].d, got_q[got_base+1].u, got_q[got_base+1].l); end
        end
        n_vec++; if (mis_cnt - mb !== 1) begin n_err++; $display("FAIL misl_pulse: got %0d pulses want 1", mis_cnt - mb); end
        n_vec++; if (pad_count_o !== 16'd4) begin n_err++; $display("FAIL misl_padcnt: got %0d want 4", pad_count_o); end
    endtask

    task automatic test_reset_mid();
        logic [23:0] e, f;
        @(posedge pixclk); #1;
        out_axis_tready = 1'b0;
        in_axis_tvalid = 1'b1; in_axis_tdata = 24'h0A0B0C; in_axis_tuser = 1'b0; in_axis_tlast = 1'b0;
        @(posedge pixclk); #1;
        in_axis_tdata = 24'h0D0E0F; in_axis_tuser = 1'b1;
        @(posedge pixclk); #1;
        in_axis_tvalid = 1'b0; in_axis_tuser = 1'b0;
        mis_exp++;
        @(negedge pixclk);
        n_vec++; if (out_axis_tvalid !== 1'b1) begin n_err++; $display("FAIL rstmid_pre_tvalid: got %b want 1", out_axis_tvalid); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if ({out_axis_tvalid, out_axis_tuser, out_axis_tlast, misalign_o} !== 4'b0000) begin n_err++; $display("FAIL rstmid_flags: got %b want 0000", {out_axis_tvalid, out_axis_tuser, out_axis_tlast, misalign_o}); end
        n_vec++; if (out_axis_tdata !== 64'h0) begin n_err++; $display("FAIL rstmid_tdata: got %h want 0", out_axis_tdata); end
        n_vec++; if (pad_count_o !== 16'h0) begin n_err++; $display("FAIL rstmid_pad: got %0d want 0", pad_count_o); end
        repeat (2) @(negedge pixclk);
        rst_n = 1'b1;
        out_axis_tready = 1'b1;
        model_reset();
        e = 24'($urandom); f = 24'($urandom);
        new_stream();
        push_pix(e, 1'b1, 1'b0); push_pix(f, 1'b0, 1'b1);
        build_expected();
        run_stream(100, 100, 0, 0);
        n_vec++; if (got_q.size() - got_base !== 1) begin n_err++; $display("FAIL rstmid_count: got %0d want 1", got_q.size() - got_base); end
        if (got_q.size() - got_base >= 1) begin
            n_vec++; if (got_q[got_base] !== mk_word(e, f, 1'b1, 1'b1)) begin n_err++; $display("FAIL rstmid_word: got %h/%b/%b want %h/1/1", got_q[got_base].d, got_q[got_base].u, got_q[got_base].l, {8'h00, f, 8'h00, e}); end
        end
    endtask

    task automatic test_backpressure();
        new_stream();
        gen_random(64);
        build_expected();
        run_stream(100, 100, 10, 5);
        n_vec++; if (stall_seen !== 1'b1) begin n_err++; $display("FAIL bp_valid_in_stall: got %b want 1", stall_seen); end
        n_vec++; if (stall_unstable !== 0) begin n_err++; $display("FAIL bp_stable: got %0d changes want 0", stall_unstable); end
        n_vec++; if (stall_rdy_hi !== 0) begin n_err++; $display("FAIL bp_tready_drop: got %0d cycles ready want 0", stall_rdy_hi); end
        n_vec++; if (rdy_drop == 0) begin n_err++; $display("FAIL bp_input_stalled: got %0d stalled cycles want >0", rdy_drop); end
        n_vec++; if (got_q.size() - got_base !== exp_q.size()) begin n_err++; $display("FAIL bp_count: got %0d want %0d", got_q.size() - got_base, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && got_base + i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[got_base+i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL bp_word %0d: got %h/%b/%b want %h/%b/%b", i, got_q[got_base+i].d, got_q[got_base+i].u, got_q[got_base+i].l, exp_q[i].d, exp_q[i].u, exp_q[i].l);
            end
        end
        n_vec++; if (pad_count_o !== exp_pad) begin n_err++; $display("FAIL bp_padcnt: got %0d want %0d", pad_count_o, exp_pad); end
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            new_stream();
            gen_random(100);
            build_expected();
            run_stream(70, 60, 0, 0);
            n_vec++; if (got_q.size() - got_base !== exp_q.size()) begin n_err++; $display("FAIL rnd_count r%0d: got %0d want %0d", r, got_q.size() - got_base, exp_q.size()); end
            for (int i = 0; i < exp_q.size() && got_base + i < got_q.size(); i++) begin
                n_vec++;
                if (got_q[got_base+i] !== exp_q[i]) begin
                    n_err++;
                    $display("FAIL rnd_word r%0d/%0d: got %h/%b/%b want %h/%b/%b", r, i, got_q[got_base+i].d, got_q[got_base+i].u, got_q[got_base+i].l, exp_q[i].d, exp_q[i].u, exp_q[i].l);
                end
            end
            n_vec++; if (pad_count_o !== exp_pad) begin n_err++; $display("FAIL rnd_padcnt r%0d: got %0d want %0d", r, pad_count_o, exp_pad); end
            n_vec++; if (mis_cnt !== mis_exp) begin n_err++; $display("FAIL rnd_misalign r%0d: got %0d want %0d", r, mis_cnt, mis_exp); end
        end
    endtask

    task automatic test_saturation();
        @(negedge pixclk) rst_n = 1'b0;
        repeat (2) @(negedge pixclk);
        rst_n = 1'b1;
        model_reset();
        rec_en = 1'b0;
        @(posedge pixclk); #1;
        out_axis_tready = 1'b1;
        in_axis_tvalid = 1'b1; in_axis_tuser = 1'b0; in_axis_tlast = 1'b1; in_axis_tdata = 24'($urandom);
        repeat (65534) @(posedge pixclk);
        #1 in_axis_tvalid = 1'b0;
        @(negedge pixclk);
        n_vec++; if (pad_count_o !== 16'hFFFE) begin n_err++; $display("FAIL sat_before: got %h want fffe", pad_count_o); end
        @(posedge pixclk); #1;
        in_axis_tvalid = 1'b1;
        repeat (5) @(posedge pixclk);
        #1 in_axis_tvalid = 1'b0; in_axis_tlast = 1'b0;
        @(negedge pixclk);
        n_vec++; if (pad_count_o !== 16'hFFFF) begin n_err++; $display("FAIL sat_hold: got %h want ffff", pad_count_o); end
        rec_en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_line4();
        test_pad3();
        test_misalign();
        test_reset_mid();
        test_backpressure();
        test_random();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
